// File: rtl/sum_job_if.sv
// Requester-side bundle for the shared triangular-sum scheduler.
// The master modport is the requester pair; the slave modport is the scheduler.
interface sum_job_if #(
  parameter int N_W = 4,
  parameter int R_W = 7
);
  logic [1:0]     req;
  logic [N_W-1:0] opnd0;
  logic [N_W-1:0] opnd1;
  logic [1:0]     gnt;
  logic           busy;
  logic           done;
  logic           done_id;
  logic [R_W-1:0] result;
  logic           ovf;
  logic [9:0]     led_out;

  modport master (
    output req, opnd0, opnd1,
    input  gnt, busy, done, done_id, result, ovf, led_out
  );

  modport slave (
    input  req, opnd0, opnd1,
    output gnt, busy, done, done_id, result, ovf, led_out
  );
endinterface

// File: rtl/sum_job_scheduler.sv
// Round-robin shared engine computing S(n) = 0+1+...+(n-1), one term per clock,
// with a tagged done pulse, saturation flag and LED status mirror.
module sum_job_scheduler #(
  parameter int N_W = 4,
  parameter int R_W = 7
) (
  input  logic     clk,
  input  logic     rst,
  sum_job_if.slave bus
);
  // Encodings double as the LED state code.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ACCUM = 3'b011,
    DONE  = 3'b111
  } state_t;

  state_t         state_reg;
  logic           prio_reg;
  logic           id_reg;
  logic [N_W-1:0] n_reg;
  logic [N_W-1:0] i_reg;
  logic [R_W:0]   acc_reg;
  logic [1:0]     gnt_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           done_id_reg;
  logic [R_W-1:0] result_reg;
  logic           ovf_reg;

  logic           pick_id;
  logic [N_W-1:0] pick_n;
  logic [N_W-1:0] n_last;
  logic [R_W+1:0] sum_wide;
  logic [R_W:0]   acc_next;

  always_comb begin
    pick_id  = (bus.req == 2'b11) ? prio_reg : bus.req[1];
    pick_n   = pick_id ? bus.opnd1 : bus.opnd0;
    n_last   = n_reg - N_W'(1);
    sum_wide = {1'b0, acc_reg} + (R_W+2)'(i_reg);
    // Clamp once past the result range so the extra acc bit acts as a sticky overflow.
    acc_next = (|sum_wide[R_W+1:R_W]) ? {1'b1, {R_W{1'b0}}} : sum_wide[R_W:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      prio_reg    <= 1'b0;
      id_reg      <= 1'b0;
      n_reg       <= '0;
      i_reg       <= '0;
      acc_reg     <= '0;
      gnt_reg     <= 2'b00;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      done_id_reg <= 1'b0;
      result_reg  <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            id_reg   <= pick_id;
            prio_reg <= ~pick_id;
            n_reg    <= pick_n;
            acc_reg  <= '0;
            i_reg    <= '0;
            gnt_reg  <= pick_id ? 2'b10 : 2'b01;
            busy_reg <= 1'b1;
            if (pick_n == '0) begin
              state_reg   <= DONE;
              done_reg    <= 1'b1;
              done_id_reg <= pick_id;
              result_reg  <= '0;
              ovf_reg     <= 1'b0;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        ACCUM: begin
          acc_reg <= acc_next;
          i_reg   <= i_reg + N_W'(1);
          if (i_reg == n_last) begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            done_id_reg <= id_reg;
            result_reg  <= acc_next[R_W] ? {R_W{1'b1}} : acc_next[R_W-1:0];
            ovf_reg     <= acc_next[R_W];
          end
        end
        DONE: begin
          state_reg <= IDLE;
          gnt_reg   <= 2'b00;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 2'b00;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.done_id = done_id_reg;
  assign bus.result  = result_reg;
  assign bus.ovf     = ovf_reg;
  assign bus.led_out = {gnt_reg, ovf_reg, 4'b0000, state_reg};
endmodule
